// File: rtl/i2s_frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_frame_buffer_pkg
// Purpose  : Shared constants, types and helpers for the I2S stereo frame
//            buffer (default sample width, default FIFO depth, frame width).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package i2s_frame_buffer_pkg;

    // Default bits per channel sample.
    localparam int c_SAMPLE_SIZE_DEFAULT = 16;

    // Default log2 of each FIFO depth in frames.
    localparam int c_DEPTH_LOG2_DEFAULT  = 3;

    // Egress action taken at a frame event.
    typedef enum logic [1:0] {
        REL_IDLE  = 2'd0,   // no frame event this cycle
        REL_FRAME = 2'd1,   // release head of egress FIFO to tx
        REL_MUTE  = 2'd2    // egress empty: mute tx and flag underrun
    } release_e;

    // A stereo frame is a left sample concatenated with a right sample.
    function automatic int frame_width(input int sample_size);
        return 2 * sample_size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_frame_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_frame_buffer_if
// Purpose  : Bundles the receive, DSP-facing, transmit and status signals of
//            the I2S frame buffer.
// Modports : master - the frame buffer itself (drives out_*, in_ready, tx_*,
//                     overflow, underrun)
//            slave  - the surrounding logic (i2s_trx receive/transmit side,
//                     DSP pipeline, status consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_frame_buffer_if
    import i2s_frame_buffer_pkg::*;
#(
    parameter int SAMPLE_SIZE = c_SAMPLE_SIZE_DEFAULT
);
    // Receive side from i2s_trx
    logic                   rx_valid;
    logic [SAMPLE_SIZE-1:0] rx_l;
    logic [SAMPLE_SIZE-1:0] rx_r;

    // Ingress frames to the DSP
    logic                   out_valid;
    logic                   out_ready;
    logic [SAMPLE_SIZE-1:0] out_l;
    logic [SAMPLE_SIZE-1:0] out_r;

    // Processed frames from the DSP
    logic                   in_valid;
    logic                   in_ready;
    logic [SAMPLE_SIZE-1:0] in_l;
    logic [SAMPLE_SIZE-1:0] in_r;

    // Transmit side to i2s_trx
    logic [SAMPLE_SIZE-1:0] tx_l;
    logic [SAMPLE_SIZE-1:0] tx_r;

    // Status
    logic                   overflow;
    logic                   underrun;
    logic                   clear_flags;

    modport master (
        input  rx_valid, rx_l, rx_r,
        output out_valid, out_l, out_r,
        input  out_ready,
        input  in_valid, in_l, in_r,
        output in_ready,
        output tx_l, tx_r,
        output overflow, underrun,
        input  clear_flags
    );

    modport slave (
        output rx_valid, rx_l, rx_r,
        input  out_valid, out_l, out_r,
        output out_ready,
        output in_valid, in_l, in_r,
        input  in_ready,
        input  tx_l, tx_r,
        input  overflow, underrun,
        output clear_flags
    );

endinterface
`default_nettype wire

// File: rtl/i2s_frame_buffer_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : frame_fifo
// Purpose  : Circular frame FIFO with registered storage, no fall-through.
//            Push while full is accepted only when a pop happens in the same
//            cycle; pop while empty is ignored.
// Ports    : sys_clk   - clock, rising edge
//            reset     - asynchronous, active-high
//            push      - write push_data this cycle
//            push_data - frame to write
//            pop       - advance read pointer this cycle
//            pop_data  - head entry (valid when empty=0)
//            full      - occupancy == depth
//            empty     - occupancy == 0
// Revision : 1.0 - initial release
// ============================================================================
module frame_fifo
    import i2s_frame_buffer_pkg::*;
#(
    parameter int WIDTH      = frame_width(c_SAMPLE_SIZE_DEFAULT),
    parameter int DEPTH_LOG2 = c_DEPTH_LOG2_DEFAULT
) (
    input  wire logic             sys_clk,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);
    localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH_CNT = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0] c_CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign full  = (r_count == c_DEPTH_CNT);
    assign empty = (r_count == '0);

    // A pop frees the slot in the same cycle, so a full FIFO may still push.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : i2s_frame_buffer
// Purpose  : Stereo frame buffer between i2s_trx and the DSP pipeline.
//            Received frames are captured once per I2S frame (rising edge of
//            rx_valid) into an ingress FIFO offered to the DSP; processed
//            frames are queued in an egress FIFO and one is released to
//            tx_l/tx_r at every frame event, muting on underrun.
// Ports    : sys_clk - sole clock, rising edge
//            reset   - asynchronous, active-high; clears all state
//            bus     - i2s_frame_buffer_if.master (rx_*, out_*, in_*, tx_*,
//                      overflow, underrun, clear_flags)
// Revision : 1.0 - initial release
// ============================================================================
module i2s_frame_buffer
    import i2s_frame_buffer_pkg::*;
#(
    parameter int SAMPLE_SIZE = c_SAMPLE_SIZE_DEFAULT,
    parameter int DEPTH_LOG2  = c_DEPTH_LOG2_DEFAULT
) (
    input wire logic         sys_clk,
    input wire logic         reset,
    i2s_frame_buffer_if.master bus
);
    localparam int c_FRAME_W = frame_width(SAMPLE_SIZE);

    logic                   r_rx_valid_q;
    logic [SAMPLE_SIZE-1:0] r_tx_l;
    logic [SAMPLE_SIZE-1:0] r_tx_r;
    logic                   r_overflow;
    logic                   r_underrun;

    logic                   w_event;
    logic                   w_ing_push;
    logic                   w_ing_pop;
    logic                   w_ing_full;
    logic                   w_ing_empty;
    logic [c_FRAME_W-1:0]   w_ing_head;
    logic                   w_ing_drop;

    logic                   w_eg_push;
    logic                   w_eg_pop;
    logic                   w_eg_full;
    logic                   w_eg_empty;
    logic [c_FRAME_W-1:0]   w_eg_head;
    release_e               w_release;

    // One event per I2S frame regardless of how long rx_valid stays high.
    assign w_event = bus.rx_valid & ~r_rx_valid_q;

    // ---------------- Ingress ----------------
    assign w_ing_pop  = bus.out_ready & ~w_ing_empty;
    assign w_ing_push = w_event & (~w_ing_full | w_ing_pop);
    // Drop the new frame (keep the oldest) only when no slot frees up.
    assign w_ing_drop = w_event & w_ing_full & ~w_ing_pop;

    frame_fifo #(
        .WIDTH      (c_FRAME_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ingress (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .push      (w_ing_push),
        .push_data ({bus.rx_l, bus.rx_r}),
        .pop       (w_ing_pop),
        .pop_data  (w_ing_head),
        .full      (w_ing_full),
        .empty     (w_ing_empty)
    );

    assign bus.out_valid = ~w_ing_empty;
    assign bus.out_l     = w_ing_head[c_FRAME_W-1:SAMPLE_SIZE];
    assign bus.out_r     = w_ing_head[SAMPLE_SIZE-1:0];

    // ---------------- Egress ----------------
    assign w_eg_push    = bus.in_valid & ~w_eg_full;
    assign bus.in_ready = ~w_eg_full;

    always_comb begin
        w_release = REL_IDLE;
        if (w_event) begin
            w_release = w_eg_empty ? REL_MUTE : REL_FRAME;
        end
    end

    assign w_eg_pop = (w_release == REL_FRAME);

    frame_fifo #(
        .WIDTH      (c_FRAME_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_egress (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .push      (w_eg_push),
        .push_data ({bus.in_l, bus.in_r}),
        .pop       (w_eg_pop),
        .pop_data  (w_eg_head),
        .full      (w_eg_full),
        .empty     (w_eg_empty)
    );

    // ---------------- Edge detect, tx registers, sticky flags ----------------
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_rx_valid_q <= 1'b0;
            r_tx_l       <= '0;
            r_tx_r       <= '0;
            r_overflow   <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_rx_valid_q <= bus.rx_valid;

            case (w_release)
                REL_FRAME: begin
                    r_tx_l <= w_eg_head[c_FRAME_W-1:SAMPLE_SIZE];
                    r_tx_r <= w_eg_head[SAMPLE_SIZE-1:0];
                end
                REL_MUTE: begin
                    r_tx_l <= '0;
                    r_tx_r <= '0;
                end
                default: begin
                    r_tx_l <= r_tx_l;
                    r_tx_r <= r_tx_r;
                end
            endcase

            // Setting wins over a simultaneous clear.
            if (w_ing_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_flags) begin
                r_overflow <= 1'b0;
            end

            if (w_release == REL_MUTE) begin
                r_underrun <= 1'b1;
            end else if (bus.clear_flags) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign bus.tx_l     = r_tx_l;
    assign bus.tx_r     = r_tx_r;
    assign bus.overflow = r_overflow;
    assign bus.underrun = r_underrun;

endmodule
`default_nettype wire
